// File: rtl/mmu_sel_scheduler.sv
// Round-robin scheduler for the MMU 5-way selector: registered one-hot select, one-cycle drive
// pulse, hold until the merged free returns, then a one-hot completion ack to the winner.
module mmu_sel_scheduler #(
   parameter int NUM_PORTS = 5,
   parameter int IDX_W     = 3,
   parameter int TIMEOUT   = 200,
   parameter int TO_W      = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NUM_PORTS-1:0] i_req,
   output logic [NUM_PORTS-1:0] o_gnt,
   output logic [NUM_PORTS-1:0] o_select,
   output logic                 o_drive,
   input  logic                 i_free,
   output logic [IDX_W-1:0]     o_grant_idx,
   output logic                 o_busy,
   output logic                 o_timeout_err,
   output logic                 o_proto_err,
   input  logic                 i_err_clr,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     ptr_q, idx_q, win_idx, next_ptr;
   logic [TO_W-1:0]      timer_q;
   logic [NUM_PORTS-1:0] sel_q, gnt_q, eff_req;
   logic                 drive_q, busy_q, to_err_q, pe_err_q;
   logic                 win_found, to_set, pe_set;
   int                   cand;

   // The port being acked this cycle is masked so it cannot win again straight away.
   always_comb begin
      eff_req   = i_req & ~gnt_q;
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = (int'(ptr_q) + i) % NUM_PORTS;
         if (!win_found && eff_req[cand]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      next_ptr = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;
      to_set   = (state_q == S_WAIT) && !i_free && (timer_q == TO_W'(TIMEOUT - 1));
      pe_set   = i_free && (state_q != S_WAIT);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         timer_q  <= '0;
         sel_q    <= '0;
         gnt_q    <= '0;
         drive_q  <= 1'b0;
         busy_q   <= 1'b0;
         to_err_q <= 1'b0;
         pe_err_q <= 1'b0;
      end else begin
         gnt_q    <= '0;
         // A set in the same cycle as a clear takes priority.
         to_err_q <= to_set | (to_err_q & ~i_err_clr);
         pe_err_q <= pe_set | (pe_err_q & ~i_err_clr);
         case (state_q)
            S_IDLE: begin
               if (win_found) begin
                  sel_q   <= NUM_PORTS'(1) << win_idx;
                  idx_q   <= win_idx;
                  drive_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               drive_q <= 1'b0;
               timer_q <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (i_free) begin
                  gnt_q   <= sel_q;
                  sel_q   <= '0;
                  ptr_q   <= next_ptr;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (to_set) begin
                  sel_q   <= '0;
                  ptr_q   <= next_ptr;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_gnt         = gnt_q;
   assign o_select      = sel_q;
   assign o_drive       = drive_q;
   assign o_grant_idx   = idx_q;
   assign o_busy        = busy_q;
   assign o_timeout_err = to_err_q;
   assign o_proto_err   = pe_err_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_mmu_sel_scheduler.sv
// Directed bench for mmu_sel_scheduler (TIMEOUT overridden to 4); each task checks its own
// scenario against hand-computed cycle-by-cycle expectations.
module tb_mmu_sel_scheduler;

   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [N-1:0] i_req = '0;
   logic         i_free = 1'b0;
   logic         i_err_clr = 1'b0;
   logic [N-1:0] o_gnt, o_select;
   logic         o_drive, o_busy, o_timeout_err, o_proto_err;
   logic [2:0]   o_grant_idx;
   logic [1:0]   o_state;

   int errors = 0;
   int checks = 0;

   mmu_sel_scheduler #(.NUM_PORTS(5), .IDX_W(3), .TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rstn(rstn), .i_req(i_req), .o_gnt(o_gnt), .o_select(o_select),
      .o_drive(o_drive), .i_free(i_free), .o_grant_idx(o_grant_idx), .o_busy(o_busy),
      .o_timeout_err(o_timeout_err), .o_proto_err(o_proto_err), .i_err_clr(i_err_clr),
      .o_state(o_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Advance one cycle; outputs are then stable for the new cycle and inputs set now are
   // sampled at the following edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; i_req = '0; i_free = 1'b0; i_err_clr = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; i_req = 5'b11111; i_free = 1'b0;
      step(); step();
      checks++; if (o_select !== 5'b0) begin errors++; $display("FAIL reset_select: got %b want 00000", o_select); end
      checks++; if (o_drive !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL reset_drive_busy: got %b%b want 00", o_drive, o_busy); end
      checks++; if (o_gnt !== 5'b0 || o_grant_idx !== 3'd0) begin errors++; $display("FAIL reset_gnt_idx: got %b/%0d want 00000/0", o_gnt, o_grant_idx); end
      checks++; if (o_timeout_err !== 1'b0 || o_proto_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b want 00", o_timeout_err, o_proto_err); end
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
      i_req = '0;
      rstn = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      i_req = 5'b00100;
      step();
      checks++; if (o_drive !== 1'b1 || o_select !== 5'b00100 || o_grant_idx !== 3'd2) begin errors++; $display("FAIL single_drive: got drive=%b sel=%b idx=%0d want 1/00100/2", o_drive, o_select, o_grant_idx); end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", o_busy); end
      step();
      checks++; if (o_drive !== 1'b0 || o_select !== 5'b00100) begin errors++; $display("FAIL single_wait: got drive=%b sel=%b want 0/00100", o_drive, o_select); end
      i_free = 1'b1;
      step();
      i_free = 1'b0; i_req = '0;
      checks++; if (o_gnt !== 5'b00100 || o_select !== 5'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL single_gnt: got gnt=%b sel=%b busy=%b want 00100/00000/0", o_gnt, o_select, o_busy); end
      step();
      checks++; if (o_gnt !== 5'b0 || o_drive !== 1'b0 || o_proto_err !== 1'b0) begin errors++; $display("FAIL single_after: got gnt=%b drive=%b perr=%b want 00000/0/0", o_gnt, o_drive, o_proto_err); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] oh;
      int k;
      do_reset();
      i_req = 5'b11111;
      step();
      for (int n = 0; n < 6; n++) begin
         k = n % N;
         oh = 5'b00001 << k;
         checks++; if (o_drive !== 1'b1 || o_grant_idx !== 3'(k) || o_select !== oh) begin errors++; $display("FAIL rr_drive%0d: got drive=%b idx=%0d sel=%b want 1/%0d/%b", n, o_drive, o_grant_idx, o_select, k, oh); end
         step();
         checks++; if (o_drive !== 1'b0 || o_select !== oh) begin errors++; $display("FAIL rr_wait%0d: got drive=%b sel=%b want 0/%b", n, o_drive, o_select, oh); end
         i_free = 1'b1;
         step();
         i_free = 1'b0;
         checks++; if (o_gnt !== oh || o_select !== 5'b0 || o_drive !== 1'b0) begin errors++; $display("FAIL rr_gnt%0d: got gnt=%b sel=%b drive=%b want %b/00000/0", n, o_gnt, o_select, o_drive, oh); end
         step();
      end
      i_req = '0;
   endtask

   task automatic test_wrap_mask();
      do_reset();
      i_req = 5'b01000;
      step();
      checks++; if (o_grant_idx !== 3'd3) begin errors++; $display("FAIL wrap_first: got idx=%0d want 3", o_grant_idx); end
      step();
      i_free = 1'b1;
      step();
      i_free = 1'b0;
      i_req = 5'b01001;
      checks++; if (o_gnt !== 5'b01000) begin errors++; $display("FAIL wrap_gnt3: got %b want 01000", o_gnt); end
      step();
      checks++; if (o_drive !== 1'b1 || o_grant_idx !== 3'd0 || o_select !== 5'b00001) begin errors++; $display("FAIL wrap_to0: got drive=%b idx=%0d sel=%b want 1/0/00001", o_drive, o_grant_idx, o_select); end
      step();
      i_free = 1'b1;
      step();
      i_free = 1'b0;
      checks++; if (o_gnt !== 5'b00001) begin errors++; $display("FAIL wrap_gnt0: got %b want 00001", o_gnt); end
      step();
      checks++; if (o_drive !== 1'b1 || o_grant_idx !== 3'd3) begin errors++; $display("FAIL wrap_back3: got drive=%b idx=%0d want 1/3", o_drive, o_grant_idx); end
      do_reset();
      i_req = 5'b00100;
      step(); step();
      i_free = 1'b1;
      step();
      i_free = 1'b0;
      checks++; if (o_gnt !== 5'b00100) begin errors++; $display("FAIL mask_gnt: got %b want 00100", o_gnt); end
      step();
      checks++; if (o_drive !== 1'b0 || o_select !== 5'b0) begin errors++; $display("FAIL mask_no_regrant: got drive=%b sel=%b want 0/00000", o_drive, o_select); end
      step();
      i_req = '0;
      checks++; if (o_drive !== 1'b1 || o_grant_idx !== 3'd2) begin errors++; $display("FAIL mask_regrant_later: got drive=%b idx=%0d want 1/2", o_drive, o_grant_idx); end
   endtask

   task automatic test_timeout();
      do_reset();
      i_req = 5'b00110;
      step();
      checks++; if (o_grant_idx !== 3'd1) begin errors++; $display("FAIL to_grant: got idx=%0d want 1", o_grant_idx); end
      i_req = 5'b00100;
      step(); step(); step(); step();
      checks++; if (o_select !== 5'b00010 || o_busy !== 1'b1 || o_timeout_err !== 1'b0) begin errors++; $display("FAIL to_last_wait: got sel=%b busy=%b terr=%b want 00010/1/0", o_select, o_busy, o_timeout_err); end
      step();
      checks++; if (o_timeout_err !== 1'b1 || o_gnt !== 5'b0 || o_select !== 5'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL to_expire: got terr=%b gnt=%b sel=%b busy=%b want 1/00000/00000/0", o_timeout_err, o_gnt, o_select, o_busy); end
      step();
      checks++; if (o_drive !== 1'b1 || o_grant_idx !== 3'd2) begin errors++; $display("FAIL to_next_req: got drive=%b idx=%0d want 1/2", o_drive, o_grant_idx); end
      i_req = '0; i_err_clr = 1'b1;
      step();
      i_err_clr = 1'b0;
      checks++; if (o_timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", o_timeout_err); end
      step(); step(); step();
      i_free = 1'b1;
      step();
      i_free = 1'b0;
      checks++; if (o_gnt !== 5'b00100 || o_timeout_err !== 1'b0 || o_proto_err !== 1'b0) begin errors++; $display("FAIL to_free_wins: got gnt=%b terr=%b perr=%b want 00100/0/0", o_gnt, o_timeout_err, o_proto_err); end
   endtask

   task automatic test_proto_err();
      do_reset();
      i_free = 1'b1;
      step();
      i_free = 1'b0;
      checks++; if (o_proto_err !== 1'b1 || o_state !== 2'd0) begin errors++; $display("FAIL perr_set: got perr=%b state=%0d want 1/0", o_proto_err, o_state); end
      i_err_clr = 1'b1; i_free = 1'b1;
      step();
      i_free = 1'b0;
      checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL perr_set_wins: got %b want 1", o_proto_err); end
      step();
      i_err_clr = 1'b0;
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b want 0", o_proto_err); end
      i_req = 5'b00001;
      step();
      i_req = '0; i_free = 1'b1;
      step();
      i_free = 1'b0;
      checks++; if (o_proto_err !== 1'b1 || o_drive !== 1'b0) begin errors++; $display("FAIL perr_drive: got perr=%b drive=%b want 1/0", o_proto_err, o_drive); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      i_req = 5'b00100;
      step(); step();
      i_free = 1'b1;
      step();
      i_free = 1'b0;
      i_req = 5'b00010;
      step();
      i_req = '0;
      step();
      checks++; if (o_select !== 5'b00010 || o_state !== 2'd2) begin errors++; $display("FAIL rmw_in_wait: got sel=%b state=%0d want 00010/2", o_select, o_state); end
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      checks++; if (o_select !== 5'b0 || o_drive !== 1'b0 || o_gnt !== 5'b0 || o_busy !== 1'b0 || o_grant_idx !== 3'd0) begin errors++; $display("FAIL rmw_outputs: got sel=%b drv=%b gnt=%b busy=%b idx=%0d want all 0", o_select, o_drive, o_gnt, o_busy, o_grant_idx); end
      i_free = 1'b1;
      step();
      i_free = 1'b0;
      checks++; if (o_proto_err !== 1'b1 || o_gnt !== 5'b0) begin errors++; $display("FAIL rmw_late_free: got perr=%b gnt=%b want 1/00000", o_proto_err, o_gnt); end
      i_req = 5'b11111;
      step();
      i_req = '0;
      checks++; if (o_grant_idx !== 3'd0 || o_drive !== 1'b1) begin errors++; $display("FAIL rmw_ptr: got idx=%0d drive=%b want 0/1", o_grant_idx, o_drive); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap_mask();
      test_timeout();
      test_proto_err();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmu_sel_scheduler.md
Name: mmu_sel_scheduler

Overview:
- Synchronous round-robin scheduler for the MMU's 5-way selector fabric.
- Arbitrates among NUM_PORTS requesters and presents a registered one-hot select plus a single-cycle drive pulse to the selector.
- Holds the select until the merged downstream free returns, then acknowledges the winning requester.
- Detects lost completions (timeout) and protocol violations (spurious free).

Parameters:
NUM_PORTS, 5, number of requesters / selector outputs
IDX_W, 3, width of granted-index output (>= clog2(NUM_PORTS))
TIMEOUT, 200, max WAIT cycles before a transaction is abandoned (1..2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
i_req  input  NUM_PORTS  per-requester level request; held until matching o_gnt bit
o_gnt  output  NUM_PORTS  one-cycle completion ack, one-hot
o_select  output  NUM_PORTS  registered one-hot select to selector; zero when idle
o_drive  output  1  one-cycle drive pulse to selector
i_free  input  1  OR of selector free-next outputs, synchronous to clk, one-cycle pulse
o_grant_idx  output  IDX_W  binary index of current/last winner
o_busy  output  1  high in DRIVE and WAIT
o_timeout_err  output  1  sticky: a transaction timed out
o_proto_err  output  1  sticky: i_free seen outside WAIT
i_err_clr  input  1  clears both sticky errors

Behaviour:
- Clock clk; reset rstn is synchronous and active-low.
- Reset (rstn=0 at a clk edge): state IDLE; ptr=0; timer=0. All outputs 0: o_select, o_drive, o_gnt, o_grant_idx, o_busy, both error flags.
- Reset mid-transaction drops the held select immediately, with no o_gnt.
  - A late i_free arriving afterwards in IDLE sets o_proto_err.
- FSM states: IDLE, DRIVE, WAIT.
- IDLE:
  - eff_req = i_req & ~o_gnt. The requester being acked this cycle is masked, so it cannot be regranted.
  - If eff_req != 0: winner k = first set bit searching from ptr upward, wrapping at NUM_PORTS-1 -> 0.
  - Registered: o_select=onehot(k), o_grant_idx=k, o_drive=1, state->DRIVE.
  - If eff_req == 0: stay in IDLE, o_select=0.
- DRIVE (exactly one cycle):
  - o_drive=1, o_select stable, o_busy=1.
  - Next edge: o_drive=0, timer=0, state->WAIT.
- WAIT:
  - o_select held, o_busy=1, timer increments each cycle.
  - On i_free=1: next edge sets o_gnt[k]=1 for one cycle, o_select=0, ptr=(k+1) mod NUM_PORTS, state->IDLE.
  - On timer==TIMEOUT-1 with i_free=0: o_timeout_err=1, no o_gnt, o_select=0, ptr=(k+1) mod NUM_PORTS, state->IDLE.
  - i_free in the final timeout cycle counts as completion (free wins over timeout).
- i_free in IDLE or DRIVE: ignored for sequencing; sets o_proto_err.
- i_err_clr clears both sticky flags. If a set and i_err_clr occur in the same cycle, set wins.
- Latency:
  - req seen in IDLE at cycle t -> o_drive/o_select high at t+1.
  - Earliest accepted i_free at t+2; o_gnt at t+3.
  - New arbitration in the same cycle as o_gnt, giving minimum 3 cycles per transaction.
- Requester contract:
  - Deassert i_req in the cycle after o_gnt is seen.
  - Dropping i_req while granted does not abort the transaction.
- i_req bits >= NUM_PORTS do not exist. o_select is never multi-hot.

Test Plan:
- Reset then single request: i_req=5'b00100 at t0, i_free pulse at t2 -> o_drive=1/o_select=00100/o_grant_idx=2 at t1; o_gnt=00100 at t3; o_select=0 at t3.
- Round-robin fairness: i_req=11111 held, i_free returned 1 cycle after each drive -> grant order 0,1,2,3,4,0; each o_gnt one-hot; never two drives without an intervening free.
- Wrap and masking: ptr=4 after a grant to port 3, i_req=01001 -> next winner port 0, then port 3; a requester re-asserting in its own o_gnt cycle is not regranted that cycle.
- Timeout: TIMEOUT=4, single grant, no i_free -> o_timeout_err=1 after 4 WAIT cycles, no o_gnt, o_select=0, next requester served. i_free on the 4th WAIT cycle -> o_gnt, no error.
- Protocol error and clear: i_free in IDLE -> o_proto_err=1. i_err_clr with a simultaneous spurious i_free -> stays 1. i_err_clr alone -> 0.
- Reset mid-WAIT: rstn=0 for one edge while o_select=00010 -> all outputs 0 next cycle. Subsequent i_free in IDLE sets o_proto_err. ptr=0.
